// File: rtl/player_controller.sv
// rtl/player_controller.sv - grid player FSM: position, facing, sprite animation and sword placement
// Define PLAYER_HURT_EN to enable the HURT/invulnerability state driven by player_hit.
module player_controller #(
  parameter int X_BITS        = 4,
  parameter int Y_BITS        = 4,
  parameter int X_MAX         = 15,
  parameter int Y_MIN         = 1,
  parameter int Y_MAX         = 11,
  parameter int X_START       = 0,
  parameter int Y_START       = 1,
  parameter int MOVE_FRAMES   = 1,
  parameter int ATTACK_FRAMES = 10,
  parameter int ANIM_PERIOD   = 21,
  parameter int ANIM_SWAP     = 7,
  parameter int HURT_FRAMES   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               input_data,
  input  logic                     frame_end,
  input  logic                     player_hit,
  output logic [X_BITS+Y_BITS-1:0] player_pos,
  output logic [1:0]               player_orientation,
  output logic [1:0]               player_direction,
  output logic [3:0]               player_sprite,
  output logic [X_BITS+Y_BITS-1:0] sword_position,
  output logic [3:0]               sword_visible,
  output logic [1:0]               sword_orientation,
  output logic [2:0]               player_state,
  output logic                     invulnerable
);
  localparam int PW = X_BITS + Y_BITS;
  localparam int MA = (MOVE_FRAMES > ATTACK_FRAMES) ? MOVE_FRAMES : ATTACK_FRAMES;
  localparam int CNT_MAX = (MA > HURT_FRAMES) ? MA : HURT_FRAMES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int AW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_MOVE = 3'd1, S_ATTACK = 3'd2, S_HURT = 3'd3} state_t;

  state_t            state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic [1:0]        dir_q, dir_d, orient_q, orient_d, sw_orient_q, sw_orient_d;
  logic [3:0]        sprite_q, sprite_d, sw_vis_q, sw_vis_d;
  logic [PW-1:0]     sw_pos_q, sw_pos_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     anim_q, anim_d;
  logic [4:0]        latch_q, latch_d, cmd;
  logic [1:0]        step_dir;
  logic [PW:0]       step_t, sword_t;
  logic              hurt_go;

  // Returns {legal, x, y} of the tile one step from (x, y) in direction d.
  function automatic logic [PW:0] adj_tile(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y,
                                           input logic [1:0] d);
    int tx;
    int ty;
    logic legal;
    tx = int'(x);
    ty = int'(y);
    case (d)
      2'b00:   ty = ty - 1;
      2'b01:   tx = tx + 1;
      2'b10:   ty = ty + 1;
      default: tx = tx - 1;
    endcase
    legal = (tx >= 0) && (tx <= X_MAX) && (ty >= Y_MIN) && (ty <= Y_MAX);
    return {legal, X_BITS'(tx), Y_BITS'(ty)};
  endfunction

  always_comb begin
    step_dir = 2'b00;
    if (cmd[3])      step_dir = 2'b01;
    else if (cmd[2]) step_dir = 2'b11;
    else if (cmd[1]) step_dir = 2'b10;
  end

  assign step_t  = adj_tile(x_q, y_q, step_dir);
  assign sword_t = adj_tile(x_q, y_q, dir_q);

`ifdef PLAYER_HURT_EN
  logic pend_q, pend_d;

  assign hurt_go = frame_end && (pend_q || player_hit) && (state_q != S_HURT);

  // Hits arriving while already hurt are dropped, not queued.
  always_comb begin
    pend_d = pend_q | player_hit;
    if ((state_q == S_HURT) || hurt_go) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign invulnerable  = (state_q == S_HURT);
  assign player_sprite = ((state_q == S_HURT) && cnt_q[0]) ? 4'b1111 : sprite_q;
`else
  logic unused_hit;
  assign unused_hit    = player_hit;
  assign hurt_go       = 1'b0;
  assign invulnerable  = 1'b0;
  assign player_sprite = sprite_q;
`endif

  always_comb begin
    cmd         = latch_q | input_data;
    latch_d     = frame_end ? 5'b0 : cmd;
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    orient_d    = orient_q;
    sprite_d    = sprite_q;
    sw_pos_d    = sw_pos_q;
    sw_vis_d    = sw_vis_q;
    sw_orient_d = sw_orient_q;
    cnt_d       = cnt_q;
    anim_d      = anim_q;
    if (frame_end) begin
      if (anim_q == AW'(ANIM_PERIOD - 1)) begin
        anim_d   = '0;
        sprite_d = 4'b0011;
      end else begin
        anim_d = anim_q + AW'(1);
        if (anim_d == AW'(ANIM_SWAP)) sprite_d = 4'b0010;
      end
      if (hurt_go) begin
        state_d  = S_HURT;
        cnt_d    = CW'(HURT_FRAMES);
        sw_vis_d = 4'b1111;
        sw_pos_d = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd[4]) begin
              state_d     = S_ATTACK;
              cnt_d       = CW'(ATTACK_FRAMES);
              sw_orient_d = dir_q;
              sw_pos_d    = sword_t[PW-1:0];
              if (sword_t[PW]) sw_vis_d = 4'b0001;
            end else if (|cmd[3:0]) begin
              state_d = S_MOVE;
              cnt_d   = CW'(MOVE_FRAMES);
              dir_d   = step_dir;
              // Mirror codes coincide with the left/right direction codes.
              if (cmd[3] || cmd[2]) orient_d = step_dir;
              if (step_t[PW]) begin
                x_d = step_t[PW-1:Y_BITS];
                y_d = step_t[Y_BITS-1:0];
              end
            end
          end
          S_MOVE: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) state_d = S_IDLE;
          end
          S_ATTACK: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) begin
              state_d  = S_IDLE;
              sw_vis_d = 4'b1111;
              sw_pos_d = '0;
            end
          end
`ifdef PLAYER_HURT_EN
          S_HURT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_d == '0) state_d = S_IDLE;
          end
`endif
          default: state_d = S_IDLE;
        endcase
      end
    end
    case (state_q)
      S_IDLE, S_MOVE, S_ATTACK: ;
`ifdef PLAYER_HURT_EN
      S_HURT: ;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      x_q         <= X_BITS'(X_START);
      y_q         <= Y_BITS'(Y_START);
      dir_q       <= 2'b01;
      orient_q    <= 2'b01;
      sprite_q    <= 4'b0011;
      sw_pos_q    <= '0;
      sw_vis_q    <= 4'b1111;
      sw_orient_q <= 2'b01;
      cnt_q       <= '0;
      anim_q      <= '0;
      latch_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      orient_q    <= orient_d;
      sprite_q    <= sprite_d;
      sw_pos_q    <= sw_pos_d;
      sw_vis_q    <= sw_vis_d;
      sw_orient_q <= sw_orient_d;
      cnt_q       <= cnt_d;
      anim_q      <= anim_d;
      latch_q     <= latch_d;
    end
  end

  assign player_pos         = {x_q, y_q};
  assign player_orientation = orient_q;
  assign player_direction   = dir_q;
  assign sword_position     = sw_pos_q;
  assign sword_visible      = sw_vis_q;
  assign sword_orientation  = sw_orient_q;
  assign player_state       = state_q;
endmodule
